// File: rtl/npu_add_tree_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : npu_add_tree_seq_if
// Description : Command, operand, result and add-tree buses of the add-tree
//               sequencer. The sequencer is the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface npu_add_tree_seq_if #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_signed;

    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [63:0]      in_para;

    logic [63:0]      tree_data;
    logic [63:0]      tree_para;
    logic             tree_signed;
    logic [18:0]      tree_result;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;

    logic             busy;

    modport master (
        output cmd_valid, cmd_len, cmd_signed,
        output in_valid, in_data, in_para,
        output out_ready, tree_result,
        input  cmd_ready, in_ready, out_valid, out_result, busy,
        input  tree_data, tree_para, tree_signed
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_signed,
        input  in_valid, in_data, in_para,
        input  out_ready, tree_result,
        output cmd_ready, in_ready, out_valid, out_result, busy,
        output tree_data, tree_para, tree_signed
    );
endinterface
`default_nettype wire

// File: rtl/npu_add_tree_seq.sv
`default_nettype none
// ============================================================================
// Module      : npu_add_tree_seq
// Description : Streams N operand beats into a registered 8-lane int8 add tree
//               and accumulates its partial sums into one result per command.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_add_tree_seq #(
    parameter int TREE_LAT = 1,
    parameter int LEN_W    = 8,
    parameter int ACC_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    npu_add_tree_seq_if.slave bus
);
    localparam int c_TREE_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [LEN_W-1:0] r_cnt;
    logic [63:0]      r_tree_data;
    logic [63:0]      r_tree_para;
    logic             r_tree_signed;
    logic [ACC_W-1:0] r_acc;

    // Tag pipeline tracks which tree outputs belong to accepted beats.
    logic [TREE_LAT:0] r_tag_valid;
    logic [TREE_LAT:0] r_tag_last;

    logic             w_cmd_ready;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_cmd_hs;
    logic             w_push_valid;
    logic             w_push_last;
    logic             w_tail_valid;
    logic             w_tail_last;
    logic [ACC_W-1:0] w_tree_ext;

    assign w_tail_valid = r_tag_valid[TREE_LAT];
    assign w_tail_last  = r_tag_last[TREE_LAT];
    assign w_cmd_hs     = w_cmd_ready & bus.cmd_valid;

    // Unsigned-data products are still signed, so sign-extend in both modes.
    assign w_tree_ext = ACC_W'($signed(bus.tree_result[c_TREE_W-1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_ready  = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_push_valid = 1'b0;
        w_push_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_push_valid = 1'b1;
                    if (r_cnt == '0) begin
                        w_push_last = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_tail_valid && w_tail_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_tree_data   <= '0;
            r_tree_para   <= '0;
            r_tree_signed <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_cnt         <= bus.cmd_len;
                r_tree_signed <= bus.cmd_signed;
            end else if (w_push_valid && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_push_valid) begin
                r_tree_data <= bus.in_data;
                r_tree_para <= bus.in_para;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_cmd_hs) begin
            r_acc <= '0;
        end else if (w_tail_valid) begin
            r_acc <= r_acc + w_tree_ext;
        end
    end

    generate
        if (TREE_LAT == 0) begin : g_tag_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_valid <= '0;
                    r_tag_last  <= '0;
                end else begin
                    r_tag_valid <= w_push_valid;
                    r_tag_last  <= w_push_last;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag_valid <= '0;
                    r_tag_last  <= '0;
                end else begin
                    r_tag_valid <= {r_tag_valid[TREE_LAT-1:0], w_push_valid};
                    r_tag_last  <= {r_tag_last[TREE_LAT-1:0], w_push_last};
                end
            end
        end
    endgenerate

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_result  = r_acc;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.tree_data   = r_tree_data;
    assign bus.tree_para   = r_tree_para;
    assign bus.tree_signed = r_tree_signed;

endmodule
`default_nettype wire

// File: tb/tb_npu_add_tree_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_add_tree_seq
// Description : Self-checking bench for npu_add_tree_seq with a registered
//               add-tree model and an int8 dot-product reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_add_tree_seq;
    localparam int TREE_LAT = 1;
    localparam int LEN_W    = 8;
    localparam int ACC_W    = 32;
    localparam int c_BOUND  = 2000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    npu_add_tree_seq_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    npu_add_tree_seq #(
        .TREE_LAT(TREE_LAT),
        .LEN_W   (LEN_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Sum over 8 lanes of data byte (signed or unsigned) times signed parameter byte.
    function automatic int beat_dot(input logic [63:0] d, input logic [63:0] p, input logic sgn);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] db;
            logic [7:0] pb;
            int         dv;
            int         pv;
            db = d[8*i +: 8];
            pb = p[8*i +: 8];
            dv = sgn ? int'($signed(db)) : int'(db);
            pv = int'($signed(pb));
            s += dv * pv;
        end
        return s;
    endfunction

    // Registered add tree, one cycle of latency.
    logic [18:0] r_tree_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tree_q <= '0;
        else        r_tree_q <= 19'(beat_dot(bus.tree_data, bus.tree_para, bus.tree_signed));
    end
    assign bus.tree_result = r_tree_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // All tasks start and end right after a falling edge.
    task automatic issue_cmd(input logic [LEN_W-1:0] len, input logic sgn);
        int n;
        bus.cmd_len    = len;
        bus.cmd_signed = sgn;
        bus.cmd_valid  = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) timed_out("cmd_ready");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [63:0] p);
        int n;
        bus.in_data  = d;
        bus.in_para  = p;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= c_BOUND) timed_out("in_ready");
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Returns the cycle index (handshake cycle = 0) in which out_valid was seen.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < c_BOUND) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= c_BOUND) timed_out("out_valid");
    endtask

    task automatic take_result(input string name, input logic [ACC_W-1:0] exp, input int delay);
        for (int i = 0; i < delay; i++) @(negedge clk);
        check(name, bus.out_result, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0]      data;
        logic [63:0]      para;
        logic             sgn;
        logic [ACC_W-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin : g_main
        int               cyc;
        logic [ACC_W-1:0] held;
        logic [ACC_W-1:0] exp;

        vecs[0] = '{64'h0101010101010101, 64'h0202020202020202, 1'b1, 32'd16};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h8080808080808080, 1'b0, 32'hFFFC0400};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h8080808080808080, 1'b1, 32'd1024};
        vecs[3] = '{64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F, 1'b1, 32'd129032};
        vecs[4] = '{64'h8080808080808080, 64'h8080808080808080, 1'b1, 32'd131072};
        vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 64'h7F7F7F7F7F7F7F7F, 1'b0, 32'd259080};
        vecs[6] = '{64'h0102030405060708, 64'h0101010101010101, 1'b1, 32'd36};
        vecs[7] = '{64'h00FF00FF00FF00FF, 64'hFF01FF01FF01FF01, 1'b0, 32'd1020};
        vecs[8] = '{64'h00FF00FF00FF00FF, 64'hFF01FF01FF01FF01, 1'b1, 32'hFFFFFFFC};

        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_len    = '0;
        bus.cmd_signed = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_para    = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cmd_ready", bus.cmd_ready, 1);
        check("rst in_ready", bus.in_ready, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst out_result", bus.out_result, 0);
        check("rst tree_data", bus.tree_data, 0);
        check("rst tree_para", bus.tree_para, 0);
        check("rst tree_signed", bus.tree_signed, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-beat table, including the output latency.
        for (int v = 0; v < 9; v++) begin
            issue_cmd(8'd0, vecs[v].sgn);
            check("busy stream", bus.busy, 1);
            check("tree_signed", bus.tree_signed, vecs[v].sgn);
            send_beat(vecs[v].data, vecs[v].para);
            wait_out(cyc);
            check($sformatf("latency v%0d", v), cyc, 2 + TREE_LAT);
            take_result($sformatf("single v%0d", v), vecs[v].exp, v % 3);
        end

        // Four beats with a two-cycle bubble between beats 2 and 3.
        issue_cmd(8'd3, 1'b1);
        send_beat(64'h0101010101010101, 64'h0202020202020202);
        send_beat(64'h0101010101010101, 64'h0202020202020202);
        @(negedge clk);
        check("bubble in_ready", bus.in_ready, 1);
        @(negedge clk);
        send_beat(64'h0101010101010101, 64'h0202020202020202);
        check("in_ready before last", bus.in_ready, 1);
        send_beat(64'h0101010101010101, 64'h0202020202020202);
        check("in_ready after last", bus.in_ready, 0);
        wait_out(cyc);
        check("multi latency", cyc, 2 + TREE_LAT);
        take_result("multi bubble", 32'd64, 0);

        // Output backpressure with competing command and beat requests.
        issue_cmd(8'd0, 1'b1);
        send_beat(64'h0101010101010101, 64'h0202020202020202);
        wait_out(cyc);
        held           = bus.out_result;
        bus.cmd_valid  = 1'b1;
        bus.cmd_len    = 8'd0;
        bus.cmd_signed = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 64'h0101010101010101;
        bus.in_para    = 64'h0202020202020202;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid", bus.out_valid, 1);
            check("bp out_result", bus.out_result, held);
            check("bp cmd_ready", bus.cmd_ready, 0);
            check("bp in_ready", bus.in_ready, 0);
        end
        check("bp result", held, 32'd16);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post out cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        check("cmd taken", bus.cmd_ready, 0);
        check("cmd taken in_ready", bus.in_ready, 1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(cyc);
        take_result("bp follow-up", 32'd16, 0);

        // Reset in the middle of a 4-beat command.
        issue_cmd(8'd3, 1'b1);
        send_beat(64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);
        send_beat(64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);
        rst_n = 1'b0;
        #1;
        check("midrst cmd_ready", bus.cmd_ready, 1);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst tree_data", bus.tree_data, 0);
        check("midrst tree_signed", bus.tree_signed, 0);
        check("midrst busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_cmd(8'd0, 1'b1);
        send_beat(64'h0303030303030303, 64'h0101010101010101);
        wait_out(cyc);
        take_result("after reset", 32'd24, 0);

        // Random commands against the reference dot product.
        for (int c = 0; c < 1000; c++) begin
            int   len;
            logic sgn;
            len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 256)) : int'($urandom_range(1, 16));
            if (c == 0) len = 256;
            sgn = 1'($urandom_range(0, 1));
            exp = '0;
            issue_cmd(8'(len - 1), sgn);
            for (int b = 0; b < len; b++) begin
                logic [63:0] d;
                logic [63:0] p;
                d = {$urandom, $urandom};
                p = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) begin
                    d = 64'hFFFFFFFFFFFFFFFF;
                    p = 64'h8080808080808080;
                end
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send_beat(d, p);
                exp = exp + ACC_W'(beat_dot(d, p, sgn));
            end
            wait_out(cyc);
            take_result("random", exp, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : g_watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/npu_add_tree_seq.md
# npu_add_tree_seq

Command-driven sequencer for the NPU 8-lane int8 add tree (`NPU_ADD_TREE_TOP`). It accepts a dot-product command of N beats and streams 64-bit data/parameter beats into the tree under a valid/ready handshake. It accumulates the tree's 19-bit per-beat partial sums into a wide accumulator and returns one result per command. It sits between the CUBE operand fetch logic and one `NPU_ADD_TREE_TOP` instance.

## Interface
- `TREE_LAT`, 1: cycles from tree inputs presented to `tree_result` valid (the tree is registered).
- `LEN_W`, 8: width of `cmd_len`.
- `ACC_W`, 32: accumulator/result width, ≥ 19.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when both high; high only in IDLE.
- `cmd_len` in LEN_W: beats minus one (0 → 1 beat, 255 → 256 beats).
- `cmd_signed` in 1: 1 = data bytes signed, 0 = data bytes unsigned; parameters always signed.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: beat accepted when both high; high only in STREAM.
- `in_data` in 64: 8 data bytes, lane i = bits [8i+7:8i].
- `in_para` in 64: 8 parameter bytes, same lane mapping.
- `tree_data` out 64: to tree `add_tree_data`, registered.
- `tree_para` out 64: to tree `add_tree_para`, registered.
- `tree_signed` out 1: to tree `is_signed_data`, registered.
- `tree_result` in 19: from tree `add_result`, two's complement.
- `out_valid` out 1: result valid, held until handshake.
- `out_ready` in 1: result consumer ready.
- `out_result` out ACC_W: signed dot product for the command.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: `cmd_ready`=1. On the cmd handshake:
  - latch `cmd_len` into the beat counter and `cmd_signed` into `tree_signed`;
  - clear the accumulator;
  - go to STREAM.
- STREAM: `in_ready`=1.
  - Each beat handshake registers `in_data`/`in_para` into `tree_data`/`tree_para` and pushes a tag (valid, last) into a TREE_LAT+1 deep shift register.
  - The counter decrements per beat. The beat accepted with the counter at 0 is tagged last; go to DRAIN.
  - Without a handshake, tree inputs hold their value and a tag with valid=0 is pushed.
- DRAIN: `in_ready`=0. The tag pipeline keeps shifting.
- Tag tail with valid=1: accumulator += sign-extend(`tree_result`) to ACC_W. Sign-extension applies in both modes, because the unsigned×signed product is signed.
- Tail tag with last=1: the final accumulate takes place and the state goes to DONE.
- DONE: `out_valid`=1 and `out_result`=accumulator, both stable. On the out handshake, go to IDLE.
- Accumulator arithmetic wraps modulo 2^ACC_W; there is no saturation and no overflow flag. The 19-bit tree result never overflows: signed max ±131072, unsigned mode min −261120.
- `tree_signed` is constant for the whole command. It changes only on cmd acceptance.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0). `in_valid` outside STREAM is ignored.

## Timing
- Reset values (async on `rst_n` low):
  - state IDLE, `cmd_ready`=1;
  - `in_ready`=0, `out_valid`=0, `busy`=0;
  - `out_result`=0, `tree_data`=0, `tree_para`=0, `tree_signed`=0;
  - all tags cleared, counter 0.
- Reset mid-command discards all in-flight beats. No result is produced for that command.
- Cmd handshake at edge E0: `in_ready`=1 in the cycle after E0.
- Beat handshake in cycle k:
  - tree inputs are presented in cycle k+1;
  - `tree_result` is sampled at the end of cycle k+1+TREE_LAT.
- Last beat handshake in cycle k: `out_valid`=1 from cycle k+2+TREE_LAT. With TREE_LAT=1 this is 3 cycles after the handshake.
- Minimum command turnaround with 1 beat, TREE_LAT=1, and `out_ready` held high is 5 cycles from cmd handshake to the next `cmd_ready`.
- Back-to-back beats are accepted every cycle, giving full throughput in STREAM. Bubbles on `in_valid` are allowed.
- Out handshake in cycle d: `cmd_ready`=1 in cycle d+1. A new command cannot be accepted in the same cycle as the out handshake.

## Test plan
- Reset: assert `rst_n`=0 mid-STREAM with 2 of 4 beats sent, then release. Required: state IDLE, `cmd_ready`=1, `out_valid`=0, `tree_data`=0. A new 1-beat command then returns a correct result, with no stale accumulation.
- Single beat, signed: `cmd_len`=0, `cmd_signed`=1, `in_data`=0x0101010101010101, `in_para`=0x0202020202020202. Required: `out_result`=16, `out_valid` exactly 3 cycles after the beat handshake.
- Unsigned extreme: `cmd_signed`=0, `in_data`=all 0xFF, `in_para`=all 0x80, 1 beat. Required: `out_result`=0xFFFC0400 (−261120). Repeat with `cmd_signed`=1: required `out_result`=1024 (−1×−128×8).
- Multi-beat with bubbles: `cmd_len`=3, 4 beats of the 16-valued operands, with `in_valid` low for 2 cycles between beats 2 and 3. Required: `out_result`=64, and `in_ready` drops the cycle after the 4th handshake.
- Output backpressure: hold `out_ready`=0 for 5 cycles in DONE while `cmd_valid`=1 and `in_valid`=1. Required: `out_result` stable, `cmd_ready`=0, `in_ready`=0, and the command is accepted the cycle after the out handshake.
- Random: 1000 commands with random length 1–256, random mode and random bytes, checked against a per-byte int8 reference model. Required: zero mismatches, including results that wrap in ACC_W.
